// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch sequencer for a nibble-wide, 8-cycle
//                machine. Walks the machine cycle counter, captures the
//                opcode nibbles (first word) or the operand nibbles (second
//                word of a two-word instruction) from the shared data bus,
//                and flags when a complete instruction is ready.
//  Ports       : clock        - single clock, rising edge
//                reset        - synchronous active-high reset (beats halt)
//                halt         - freezes all state while high
//                data[3:0]    - shared nibble data bus
//                cycle[2:0]   - current machine cycle 0..7
//                sync         - high while cycle == 7
//                inst_opr     - upper opcode nibble
//                inst_opa     - lower opcode nibble
//                inst_operand - second instruction word {hi, lo}
//                word_phase   - 0 = first word, 1 = second word
//                two_word     - current opcode needs a second word
//                exec_valid   - complete instruction available (cycles 5..7)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch (
    input  logic       clock,
    input  logic       reset,
    input  logic       halt,
    input  logic [3:0] data,
    output logic [2:0] cycle,
    output logic       sync,
    output logic [3:0] inst_opr,
    output logic [3:0] inst_opa,
    output logic [7:0] inst_operand,
    output logic       word_phase,
    output logic       two_word,
    output logic       exec_valid
);

    // Bus sampling points within the 8-cycle machine cycle
    localparam logic [2:0] C_CYC_HI   = 3'd3;   // upper nibble on the bus
    localparam logic [2:0] C_CYC_LO   = 3'd4;   // lower nibble on the bus
    localparam logic [2:0] C_CYC_EXEC = 3'd5;   // first execute cycle
    localparam logic [2:0] C_CYC_LAST = 3'd7;   // end of machine cycle

    logic [2:0] cycle_q,      cycle_d;
    logic       word_phase_q, word_phase_d;
    logic [3:0] opr_q,        opr_d;
    logic [3:0] opa_q,        opa_d;
    logic [7:0] operand_q,    operand_d;
    logic       w_two_word;

    // Two-word opcodes: JCN(1), JUN(4), JMS(5), ISZ(7), and FIM (2 with
    // even opa). Opr 2 with odd opa is the single-word SRC.
    always_comb begin
        w_two_word = 1'b0;
        case (opr_q)
            4'h1, 4'h4, 4'h5, 4'h7: w_two_word = 1'b1;
            4'h2:                   w_two_word = ~opa_q[0];
            default:                w_two_word = 1'b0;
        endcase
    end

    always_comb begin
        cycle_d      = cycle_q;
        word_phase_d = word_phase_q;
        opr_d        = opr_q;
        opa_d        = opa_q;
        operand_d    = operand_q;
        if (!halt) begin
            cycle_d = cycle_q + 3'd1;   // 7 wraps to 0 by width
            if (cycle_q == C_CYC_HI) begin
                if (word_phase_q) operand_d[7:4] = data;
                else              opr_d          = data;
            end
            if (cycle_q == C_CYC_LO) begin
                if (word_phase_q) operand_d[3:0] = data;
                else              opa_d          = data;
            end
            // Phase decision uses the opcode captured in this machine cycle;
            // a second word always returns to phase 0.
            if (cycle_q == C_CYC_LAST) begin
                word_phase_d = ~word_phase_q & w_two_word;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q      <= 3'd0;
            word_phase_q <= 1'b0;
            opr_q        <= 4'h0;
            opa_q        <= 4'h0;
            operand_q    <= 8'h00;
        end else begin
            cycle_q      <= cycle_d;
            word_phase_q <= word_phase_d;
            opr_q        <= opr_d;
            opa_q        <= opa_d;
            operand_q    <= operand_d;
        end
    end

    assign cycle        = cycle_q;
    assign sync         = (cycle_q == C_CYC_LAST);
    assign inst_opr     = opr_q;
    assign inst_opa     = opa_q;
    assign inst_operand = operand_q;
    assign word_phase   = word_phase_q;
    assign two_word     = w_two_word;
    // A first word of a two-word instruction is not yet executable.
    assign exec_valid   = (cycle_q >= C_CYC_EXEC) && (word_phase_q || !w_two_word);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Self-checking bench for inst_fetch. A behavioural model is
//                compared with the DUT after every clock edge, and directed
//                fetch sequences carry hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       halt  = 1'b0;
    logic [3:0] data  = 4'h0;
    logic [2:0] cycle;
    logic       sync;
    logic [3:0] inst_opr;
    logic [3:0] inst_opa;
    logic [7:0] inst_operand;
    logic       word_phase;
    logic       two_word;
    logic       exec_valid;

    int total = 0;
    int bad   = 0;

    inst_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .halt         (halt),
        .data         (data),
        .cycle        (cycle),
        .sync         (sync),
        .inst_opr     (inst_opr),
        .inst_opa     (inst_opa),
        .inst_operand (inst_operand),
        .word_phase   (word_phase),
        .two_word     (two_word),
        .exec_valid   (exec_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cyc = 0, m_ph = 0, m_opr = 0, m_opa = 0, m_hi = 0, m_lo = 0;
    bit m_ok = 0;

    function automatic bit m_two(input int opr, input int opa);
        return (opr == 1 || opr == 4 || opr == 5 || opr == 7) ||
               (opr == 2 && (opa % 2) == 0);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_cyc = 0; m_ph = 0; m_opr = 0; m_opa = 0; m_hi = 0; m_lo = 0;
            m_ok  = 1;
        end else if (m_ok && !halt) begin
            if (m_cyc == 3) begin if (m_ph == 1) m_hi = int'(data); else m_opr = int'(data); end
            if (m_cyc == 4) begin if (m_ph == 1) m_lo = int'(data); else m_opa = int'(data); end
            if (m_cyc == 7) m_ph = (m_ph == 0 && m_two(m_opr, m_opa)) ? 1 : 0;
            m_cyc = (m_cyc + 1) % 8;
        end
        #1;
        if (m_ok) begin
            int ev;
            ev = (m_cyc >= 5 && (m_ph == 1 || !m_two(m_opr, m_opa))) ? 1 : 0;
            chk("m_cycle",      {5'd0, cycle},      8'(m_cyc));
            chk("m_sync",       {7'd0, sync},       8'(m_cyc == 7));
            chk("m_opr",        {4'd0, inst_opr},   8'(m_opr));
            chk("m_opa",        {4'd0, inst_opa},   8'(m_opa));
            chk("m_operand",    inst_operand,       8'(m_hi * 16 + m_lo));
            chk("m_word_phase", {7'd0, word_phase}, 8'(m_ph));
            chk("m_two_word",   {7'd0, two_word},   8'(m_two(m_opr, m_opa)));
            chk("m_exec_valid", {7'd0, exec_valid}, 8'(ev));
        end
    end

    // ---------------- directed stimulus ----------------
    // Drive inputs at a falling edge; return after the next falling edge,
    // so exactly one rising edge has consumed them.
    task automatic clk1(input logic h, input logic r, input logic [3:0] d);
        halt = h; reset = r; data = d;
        @(negedge clock);
    endtask

    // One machine cycle starting at cycle 0: hi nibble at cycle 3, lo at 4.
    // Optional halt of hold_n clocks inserted while sitting at hold_at.
    task automatic fetch(input logic [3:0] hi, input logic [3:0] lo,
                         input logic exp_exec, input logic exp_ph_after,
                         input int hold_at, input int hold_n);
        for (int i = 0; i < 8; i++) begin
            if (i == hold_at) begin
                for (int k = 0; k < hold_n; k++) begin
                    clk1(1'b1, 1'b0, 4'hE);
                    chk("halt_cycle", {5'd0, cycle}, 8'(hold_at));
                end
            end
            clk1(1'b0, 1'b0, (i == 3) ? hi : (i == 4) ? lo : 4'hF);
            if (((i + 1) % 8) >= 5) chk("exec_hi_win", {7'd0, exec_valid}, {7'd0, exp_exec});
            else                    chk("exec_lo_win", {7'd0, exec_valid}, 8'd0);
        end
        chk("phase_after", {7'd0, word_phase}, {7'd0, exp_ph_after});
    endtask

    initial begin
        @(negedge clock);
        clk1(1'b0, 1'b1, 4'h0);
        clk1(1'b1, 1'b1, 4'h0);           // reset beats halt
        chk("rst_cycle",   {5'd0, cycle},      8'd0);
        chk("rst_sync",    {7'd0, sync},       8'd0);
        chk("rst_two",     {7'd0, two_word},   8'd0);
        chk("rst_exec",    {7'd0, exec_valid}, 8'd0);
        chk("rst_operand", inst_operand,       8'h00);

        // Free-running counter: 0..7,0..7
        for (int i = 1; i <= 16; i++) begin
            clk1(1'b0, 1'b0, 4'h0);
            chk("free_cycle", {5'd0, cycle}, 8'(i % 8));
            chk("free_sync",  {7'd0, sync},  8'((i % 8) == 7));
        end

        // One-word fetch
        fetch(4'hD, 4'h5, 1'b1, 1'b0, -1, 0);
        chk("ow_opr", {4'd0, inst_opr}, 8'h0D);
        chk("ow_opa", {4'd0, inst_opa}, 8'h05);
        chk("ow_two", {7'd0, two_word}, 8'd0);

        // Two-word fetch
        fetch(4'h4, 4'h1, 1'b0, 1'b1, -1, 0);
        chk("tw_two", {7'd0, two_word}, 8'd1);
        fetch(4'hA, 4'hB, 1'b1, 1'b0, -1, 0);
        chk("tw_operand", inst_operand,     8'hAB);
        chk("tw_opr",     {4'd0, inst_opr}, 8'h04);
        chk("tw_opa",     {4'd0, inst_opa}, 8'h01);

        // FIM / SRC split and a few more opcodes
        fetch(4'h2, 4'h4, 1'b0, 1'b1, -1, 0);
        chk("fim_two", {7'd0, two_word}, 8'd1);
        fetch(4'h3, 4'h3, 1'b1, 1'b0, -1, 0);
        chk("fim_operand", inst_operand, 8'h33);
        fetch(4'h2, 4'h5, 1'b1, 1'b0, -1, 0);
        chk("src_two", {7'd0, two_word}, 8'd0);
        fetch(4'h3, 4'h0, 1'b1, 1'b0, -1, 0);
        fetch(4'h7, 4'h0, 1'b0, 1'b1, -1, 0);
        fetch(4'h0, 4'h0, 1'b1, 1'b0, -1, 0);
        chk("isz_operand", inst_operand, 8'h00);

        // Halt for 3 clocks at cycle 4 of phase 1
        fetch(4'h5, 4'h0, 1'b0, 1'b1, -1, 0);
        fetch(4'hC, 4'h6, 1'b1, 1'b0, 4, 3);
        chk("halt_operand", inst_operand,     8'hC6);
        chk("halt_opr",     {4'd0, inst_opr}, 8'h05);

        // Reset at cycle 5 of phase 1
        fetch(4'h1, 4'h2, 1'b0, 1'b1, -1, 0);
        for (int i = 0; i < 5; i++)
            clk1(1'b0, 1'b0, (i == 3) ? 4'h9 : (i == 4) ? 4'h8 : 4'hF);
        chk("mid_operand", inst_operand, 8'h98);
        chk("mid_exec",    {7'd0, exec_valid}, 8'd1);
        clk1(1'b1, 1'b1, 4'h0);
        chk("mr_cycle",   {5'd0, cycle},      8'd0);
        chk("mr_phase",   {7'd0, word_phase}, 8'd0);
        chk("mr_opr",     {4'd0, inst_opr},   8'h00);
        chk("mr_operand", inst_operand,       8'h00);
        fetch(4'hD, 4'h5, 1'b1, 1'b0, -1, 0);

        clk1(1'b0, 1'b0, 4'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
